// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: arms, pre-fills, hunts for a trigger edge, captures the post-trigger
// span into the sample ring buffer and hands the frame to the display. Optional hysteresis via TRIG_HYST_EN.
module acq_trigger_ctrl #(
    parameter int DATA_W  = 12,
    parameter int ADDR_W  = 10,
    parameter int AUTO_TO = 1048576,
    parameter int HYST    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [1:0]        trig_mode,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic              arm,
    input  logic              stop,
    input  logic              display_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] frame_start,
    output logic              trig_forced,
    output logic              frame_done,
    output logic              busy,
    output logic [2:0]        state_o
);

    localparam int CNT_W = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] pre_len;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic [CNT_W-1:0]  auto_cnt;
    logic              force_trig;
    logic              wr;
    logic              rearm;
    logic              edge_hit;
    logic              forced_hit;
    logic              trig_hit;

`ifdef TRIG_HYST_EN
    localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);

    logic [DATA_W-1:0] lvl_lo, lvl_hi;
    logic              qual;

    // Re-qualification thresholds, saturated at the ends of the sample range
    always_comb begin
        lvl_lo = (trig_level >= HYST_V) ? trig_level - HYST_V : '0;
        lvl_hi = (trig_level <= ~HYST_V) ? trig_level + HYST_V : '1;
    end
`endif

    always_comb begin
        edge_hit = 1'b0;
        if (prev_valid) begin
            if (trig_edge)
                edge_hit = (prev > trig_level) && (sample_data <= trig_level);
            else
                edge_hit = (prev < trig_level) && (sample_data >= trig_level);
        end
`ifdef TRIG_HYST_EN
        edge_hit = edge_hit && qual;
`endif
        forced_hit = force_trig && (trig_mode == 2'd0);
        trig_hit   = sample_valid && (edge_hit || forced_hit);
    end

    // Zero-length pre/post spans move on after one idle cycle so a frame is always DEPTH samples
    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        rearm     = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = PRE_FILL;
                    rearm     = 1'b1;
                end
            end
            PRE_FILL: begin
                if (pre_len == '0) begin
                    state_nxt = ARMED;
                end else begin
                    wr = sample_valid;
                    if (sample_valid && (pre_cnt == pre_len - ADDR_W'(1)))
                        state_nxt = ARMED;
                end
            end
            ARMED: begin
                wr = sample_valid;
                if (trig_hit)
                    state_nxt = POST;
            end
            POST: begin
                if (post_cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    wr = sample_valid;
                    if (sample_valid && (post_cnt == ADDR_W'(1)))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (arm || (display_ack && !trig_mode[1])) begin
                    state_nxt = PRE_FILL;
                    rearm     = 1'b1;
                end else if (display_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
            rearm     = 1'b0;
        end
    end

    assign wr_en   = wr;
    assign wr_addr = ptr;
    assign wr_data = wr ? sample_data : '0;
    assign busy    = (state == PRE_FILL) || (state == ARMED) || (state == POST);
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            pre_len     <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            auto_cnt    <= '0;
            force_trig  <= 1'b0;
            trig_addr   <= '0;
            frame_start <= '0;
            trig_forced <= 1'b0;
            frame_done  <= 1'b0;
`ifdef TRIG_HYST_EN
            qual        <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            frame_done <= (state_nxt == DONE) && (state != DONE);
            if (wr)
                ptr <= ptr + ADDR_W'(1);
            if (rearm) begin
                pre_len     <= pretrig_len;
                pre_cnt     <= '0;
                prev_valid  <= 1'b0;
                trig_forced <= 1'b0;
            end
            if (state == PRE_FILL && wr)
                pre_cnt <= pre_cnt + ADDR_W'(1);
            if (state == POST && wr)
                post_cnt <= post_cnt - ADDR_W'(1);

            // Timeout counter and hysteresis qualifier only live while hunting for an edge
            if (state == ARMED) begin
                if (!force_trig) begin
                    if (auto_cnt == CNT_W'(AUTO_TO - 1))
                        force_trig <= 1'b1;
                    else
                        auto_cnt <= auto_cnt + CNT_W'(1);
                end
                if (sample_valid) begin
                    prev       <= sample_data;
                    prev_valid <= 1'b1;
`ifdef TRIG_HYST_EN
                    if (trig_edge ? (sample_data >= lvl_hi) : (sample_data <= lvl_lo))
                        qual <= 1'b1;
`endif
                end
                if (trig_hit && !stop) begin
                    trig_addr   <= ptr;
                    frame_start <= ptr - pre_len;
                    post_cnt    <= '1 - pre_len;
                    trig_forced <= forced_hit;
                end
            end else begin
                auto_cnt   <= '0;
                force_trig <= 1'b0;
`ifdef TRIG_HYST_EN
                qual       <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Self-checking bench for acq_trigger_ctrl: directed frames pinned by literals, then randomized
// traffic compared every cycle against a behavioural model of the acquisition sequence.
module tb_acq_trigger_ctrl;

    localparam int DATA_W  = 12;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam int AUTO_TO = 32;
    localparam int HYST    = 8;
    localparam int MAXV    = 4095;

    localparam int S_IDLE  = 0;
    localparam int S_PRE   = 1;
    localparam int S_ARMED = 2;
    localparam int S_POST  = 3;
    localparam int S_DONE  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic [DATA_W-1:0] trig_level = '0;
    logic              trig_edge = 1'b0;
    logic [1:0]        trig_mode = 2'd0;
    logic [ADDR_W-1:0] pretrig_len = '0;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic              display_ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] frame_start;
    logic              trig_forced;
    logic              frame_done;
    logic              busy;
    logic [2:0]        state_o;

    acq_trigger_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .AUTO_TO(AUTO_TO),
        .HYST   (HYST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .trig_mode   (trig_mode),
        .pretrig_len (pretrig_len),
        .arm         (arm),
        .stop        (stop),
        .display_ack (display_ack),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .trig_addr   (trig_addr),
        .frame_start (frame_start),
        .trig_forced (trig_forced),
        .frame_done  (frame_done),
        .busy        (busy),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    int fd_count = 0;
    bit chk_en   = 1'b0;

    // Behavioural model of one acquisition: phase, ring pointer and span bookkeeping
    int m_state, m_ptr, m_pre_len, m_pre_written, m_post_left;
    int m_prev, m_armed_cycles, m_trig_addr, m_frame_start;
    bit m_prev_valid, m_forced, m_frame_done, m_qual;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic a,
                                 input logic s, input logic k);
        sample_valid = v;
        sample_data  = d;
        arm          = a;
        stop         = s;
        display_ack  = k;
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_wr();
        case (m_state)
            S_PRE:   return sample_valid && (m_pre_written < m_pre_len);
            S_ARMED: return sample_valid;
            S_POST:  return sample_valid && (m_post_left > 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic void start_frame();
        m_state       = S_PRE;
        m_pre_len     = int'(pretrig_len);
        m_pre_written = 0;
        m_prev_valid  = 1'b0;
        m_forced      = 1'b0;
    endfunction

    function automatic void enter_armed();
        m_state        = S_ARMED;
        m_armed_cycles = 0;
        m_qual         = 1'b0;
    endfunction

    always @(posedge clk) begin
        bit do_wr, crossed, forced_now;
        int old_ptr, old_state, cur, lvl, lo, hi;
        if (rst) begin
            m_state = S_IDLE; m_ptr = 0; m_pre_len = 0; m_pre_written = 0; m_post_left = 0;
            m_prev = 0; m_prev_valid = 0; m_armed_cycles = 0; m_trig_addr = 0;
            m_frame_start = 0; m_forced = 0; m_frame_done = 0; m_qual = 0;
        end else begin
            do_wr     = model_wr();
            old_ptr   = m_ptr;
            old_state = m_state;
            cur       = int'(sample_data);
            lvl       = int'(trig_level);
            lo        = (lvl >= HYST) ? lvl - HYST : 0;
            hi        = (lvl + HYST > MAXV) ? MAXV : lvl + HYST;
            if (do_wr) m_ptr = (m_ptr + 1) % DEPTH;
            m_frame_done = 1'b0;
            if (stop) begin
                m_state = S_IDLE;
            end else begin
                case (m_state)
                    S_IDLE: if (arm) start_frame();
                    S_DONE: begin
                        if (arm || (display_ack && trig_mode < 2)) start_frame();
                        else if (display_ack) m_state = S_IDLE;
                    end
                    S_PRE: begin
                        if (m_pre_len == 0) enter_armed();
                        else if (do_wr) begin
                            m_pre_written++;
                            if (m_pre_written == m_pre_len) enter_armed();
                        end
                    end
                    S_ARMED: begin
                        forced_now = (trig_mode == 2'd0) && (m_armed_cycles >= AUTO_TO);
                        if (sample_valid) begin
                            crossed = m_prev_valid && (trig_edge ? (m_prev > lvl && cur <= lvl)
                                                                 : (m_prev < lvl && cur >= lvl));
`ifdef TRIG_HYST_EN
                            crossed = crossed && m_qual;
                            if (trig_edge ? (cur >= hi) : (cur <= lo)) m_qual = 1'b1;
`endif
                            if (crossed || forced_now) begin
                                m_trig_addr   = old_ptr;
                                m_frame_start = (old_ptr - m_pre_len + DEPTH) % DEPTH;
                                if (forced_now) m_forced = 1'b1;
                                m_post_left   = DEPTH - 1 - m_pre_len;
                                m_state       = S_POST;
                            end
                            m_prev       = cur;
                            m_prev_valid = 1'b1;
                        end
                        m_armed_cycles++;
                    end
                    S_POST: begin
                        if (m_post_left == 0) m_state = S_DONE;
                        else if (do_wr) begin
                            m_post_left--;
                            if (m_post_left == 0) m_state = S_DONE;
                        end
                    end
                    default: m_state = S_IDLE;
                endcase
            end
            if (m_state == S_DONE && old_state != S_DONE) m_frame_done = 1'b1;
        end
    end

    // Outputs are stable mid-cycle; compare everything against the model on the falling edge
    always @(negedge clk) begin
        bit exp_wr;
        if (chk_en) begin
            exp_wr = model_wr();
            checkOutput("wr_en", int'(wr_en), int'(exp_wr));
            checkOutput("wr_addr", int'(wr_addr), m_ptr);
            if (exp_wr) checkOutput("wr_data", int'(wr_data), int'(sample_data));
            checkOutput("busy", int'(busy), int'(m_state >= S_PRE && m_state <= S_POST));
            checkOutput("state_o", int'(state_o), m_state);
            checkOutput("trig_addr", int'(trig_addr), m_trig_addr);
            checkOutput("frame_start", int'(frame_start), m_frame_start);
            checkOutput("trig_forced", int'(trig_forced), int'(m_forced));
            checkOutput("frame_done", int'(frame_done), int'(m_frame_done));
            if (wr_en) wr_count++;
            if (frame_done) fd_count++;
        end
    end

    initial begin
        int n, fd_before;

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        checkOutput("rst_state", int'(state_o), 0);
        checkOutput("rst_wr_en", int'(wr_en), 0);
        checkOutput("rst_wr_addr", int'(wr_addr), 0);
        checkOutput("rst_trig_addr", int'(trig_addr), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Normal, rising, level 100, 4 pre samples, ramp 0,10,20...: crossing 90->100 at address 10
        $display("[TB] directed: normal rising ramp");
        trig_mode = 2'd1; trig_edge = 1'b0; trig_level = 12'd100; pretrig_len = 4'd4;
        wr_count = 0; fd_count = 0;
        applyStimulus(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 12'(i * 10), 1'b0, 1'b0, 1'b0);
            if (state_o == 3'd4) break;
        end
        checkOutput("s1_done", int'(state_o), 4);
        checkOutput("s1_trig_addr", int'(trig_addr), 10);
        checkOutput("s1_model_trig_addr", m_trig_addr, 10);
        checkOutput("s1_frame_start", int'(frame_start), 6);
        checkOutput("s1_wr_addr", int'(wr_addr), 6);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("s1_writes", wr_count, 22);
        checkOutput("s1_done_pulses", fd_count, 1);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("s1_rearm", int'(state_o), 1);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("s1_stop", int'(state_o), 0);

        // Single, falling, level 50, no pre samples: 80,60,40 triggers on 40 at address 8
        $display("[TB] directed: single falling");
        trig_mode = 2'd2; trig_edge = 1'b1; trig_level = 12'd50; pretrig_len = 4'd0;
        applyStimulus(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_armed", int'(state_o), 2);
        applyStimulus(1'b1, 12'd80, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd60, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd40, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_post", int'(state_o), 3);
        checkOutput("s2_trig_addr", int'(trig_addr), 8);
        checkOutput("s2_frame_start", int'(frame_start), 8);
        repeat (15) applyStimulus(1'b1, 12'd40, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_done", int'(state_o), 4);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("s2_idle", int'(state_o), 0);
        repeat (3) applyStimulus(1'b1, 12'd40, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_no_write", int'(wr_en), 0);

        // Auto, 15 pre samples, flat 10: forced on the 33rd ARMED sample at address 7, start wraps to 8
        $display("[TB] directed: auto timeout");
        trig_mode = 2'd0; trig_edge = 1'b0; trig_level = 12'd100; pretrig_len = 4'd15;
        applyStimulus(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
        repeat (15) applyStimulus(1'b1, 12'd10, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_armed", int'(state_o), 2);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 12'd10, 1'b0, 1'b0, 1'b0);
            n++;
            if (state_o != 3'd2) break;
        end
        checkOutput("s3_forced_sample", n, 33);
        checkOutput("s3_trig_forced", int'(trig_forced), 1);
        checkOutput("s3_trig_addr", int'(trig_addr), 7);
        checkOutput("s3_frame_start", int'(frame_start), 8);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_done", int'(state_o), 4);

        // Re-arm through display_ack, real edge at address 11, then stop+arm in POST
        $display("[TB] directed: stop in POST");
        pretrig_len = 4'd2;
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 12'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd200, 1'b0, 1'b0, 1'b0);
        checkOutput("s4_post", int'(state_o), 3);
        applyStimulus(1'b1, 12'd20, 1'b0, 1'b0, 1'b0);
        fd_before = fd_count;
        applyStimulus(1'b1, 12'd20, 1'b1, 1'b1, 1'b0);
        checkOutput("s4_stop_idle", int'(state_o), 0);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("s4_no_done", fd_count, fd_before);
        checkOutput("s4_trig_addr", int'(trig_addr), 11);
        checkOutput("s4_trig_forced", int'(trig_forced), 0);

`ifdef TRIG_HYST_EN
        $display("[TB] directed: hysteresis");
        trig_mode = 2'd1; trig_edge = 1'b0; trig_level = 12'd100; pretrig_len = 4'd0;
        applyStimulus(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd97, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd101, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd97, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd101, 1'b0, 1'b0, 1'b0);
        checkOutput("hy_no_trig", int'(state_o), 2);
        applyStimulus(1'b1, 12'd90, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 12'd101, 1'b0, 1'b0, 1'b0);
        checkOutput("hy_trig", int'(state_o), 3);
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized traffic: model comparison runs every cycle
        $display("[TB] random phase");
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) begin
                trig_mode   = 2'($urandom_range(0, 3));
                trig_edge   = 1'($urandom_range(0, 1));
                trig_level  = 12'($urandom_range(20, 200));
                pretrig_len = 4'($urandom_range(0, 15));
            end
            applyStimulus(1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 255)),
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 5) == 0));
        end
        rst = 1'b0;
        applyStimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
